wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: CNT_W, 32, width of the retired-instruction counter.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-004 in_valid  input  1  MEM stage presents a retiring instruction.
REQ-005 in_ready  output  1  stage accepts the instruction this cycle.
REQ-006 in_regwen  input  1  instruction writes a destination register.
REQ-007 in_rd  input  5  destination register index.
REQ-008 in_wbsel  input  2  writeback source: 0 ALU, 1 load, 2 PC+4, 3 reserved (treated as ALU).
REQ-009 in_alu  input  32  ALU result; for loads, the effective address.
REQ-010 in_pc  input  32  instruction PC.
REQ-011 in_funct3  input  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
REQ-012 ld_rsp_valid  input  1  data memory returns load data this cycle.
REQ-013 ld_rsp_data  input  32  raw aligned memory word.
REQ-014 RegWEn  output  1  register-file write enable.
REQ-015 regD  output  5  register-file write index.
REQ-016 wb_data  output  32  register-file write data.
REQ-017 busy  output  1  1 while a load response is outstanding.
REQ-018 retire_cnt  output  CNT_W  count of accepted instructions.
REQ-019 err_flags  output  2  sticky: [0] unexpected load response, [1] illegal or misaligned load.

Function
REQ-020 The FSM SHALL have two states: IDLE and WAIT_LD.
REQ-021 in_ready SHALL be 1 in IDLE and 0 in WAIT_LD.
REQ-022 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; retire_cnt SHALL increment by 1 mod 2^CNT_W at that edge.
REQ-023 Non-load accept (in_wbsel!=1): the write SHALL be presented during the cycle following acceptance; RegWEn is high for exactly that one cycle. Sustained throughput SHALL be one instruction per cycle.
REQ-024 wb_data SHALL be in_alu for wbsel 0 or 3, and in_pc+4 (mod 2^32) for wbsel 2.
REQ-025 Load accept (in_wbsel=1): the FSM SHALL latch rd, regwen, funct3 and addr[1:0], then move to WAIT_LD.
REQ-026 ld_rsp_valid SHALL be sampled only in WAIT_LD. A response in the acceptance cycle is not sampled.
REQ-027 On ld_rsp_valid in WAIT_LD: the stage SHALL latch the extracted data, present the write in the next cycle, and return to IDLE; in_ready becomes 1 in that same next cycle.
REQ-028 Byte extraction: byte at addr[1:0]*8. Halfword extraction: bits [addr[1]*16 +: 16]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-029 LH/LHU with addr[0]=1, LW with addr[1:0]!=0, or funct3 of 3, 6 or 7: the stage SHALL set err_flags[1] and behave as LW with the offset ignored (3/6/7), or use the masked offset (misaligned cases).
REQ-030 ld_rsp_valid in IDLE SHALL be ignored for data and SHALL set err_flags[0].
REQ-031 RegWEn SHALL be forced to 0 when the latched regwen=0 or the latched rd=0; the instruction still retires.
REQ-032 When RegWEn=0, regD and wb_data hold their last values.
REQ-033 busy SHALL equal (state==WAIT_LD).

Reset
REQ-034 While reset=0 (asynchronous assertion): state=IDLE, RegWEn=0, regD=0, wb_data=0, retire_cnt=0, err_flags=0, busy=0. An outstanding load is abandoned.
REQ-035 Reset deassertion SHALL be sampled synchronously; the first acceptance is possible on the first rising edge with reset=1.

Verification
REQ-036 ALU back-to-back: rd=5 alu=0x11, then rd=6 alu=0x22 on consecutive cycles -> RegWEn=1 on the two following cycles with (5,0x11), (6,0x22); retire_cnt=2.
REQ-037 LB sign-extend: addr=0x1003, rsp 0x80FF_0000 after 3 wait cycles -> in_ready=0 for 4 cycles; write rd with 0xFFFFFF80; busy drops with the write.
REQ-038 LHU/LH: addr=0x2002, data 0x8001_1234 -> LHU writes 0x00008001; LH writes 0xFFFF8001. LH at addr 0x2001 sets err_flags=2'b10.
REQ-039 JAL-type: wbsel=2, pc=0xFFFF_FFFC, rd=1 -> wb_data=0x00000000. rd=0 -> RegWEn stays 0, retire_cnt still increments.
REQ-040 Unexpected response: ld_rsp_valid=1 in IDLE -> no write, err_flags[0]=1 until reset.
REQ-041 Reset mid-load: reset=0 in WAIT_LD, then rsp arrives after release -> no write, state IDLE, err_flags=2'b01, retire_cnt=0.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU/JAL results in one cycle and holds the pipe for
// a single outstanding load, extracting and extending the returned word.
module wb_stage #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_regwen,
   input  logic [4:0]       in_rd,
   input  logic [1:0]       in_wbsel,
   input  logic [31:0]      in_alu,
   input  logic [31:0]      in_pc,
   input  logic [2:0]       in_funct3,
   input  logic             ld_rsp_valid,
   input  logic [31:0]      ld_rsp_data,
   output logic             RegWEn,
   output logic [4:0]       regD,
   output logic [31:0]      wb_data,
   output logic             busy,
   output logic [CNT_W-1:0] retire_cnt,
   output logic [1:0]       err_flags
);

   typedef enum logic {IDLE = 1'b0, WAIT_LD = 1'b1} state_t;

   state_t           r_state;
   logic             r_regwen;
   logic [4:0]       r_regd;
   logic [31:0]      r_wb_data;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_err;
   logic             r_ld_regwen;
   logic [4:0]       r_ld_rd;
   logic [2:0]       r_ld_f3;
   logic [1:0]       r_ld_off;

   logic [31:0]      w_alu_data;
   logic             w_ld_bad;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [31:0]      w_ld_data;

   assign in_ready   = (r_state == IDLE);
   assign busy       = (r_state == WAIT_LD);
   assign RegWEn     = r_regwen;
   assign regD       = r_regd;
   assign wb_data    = r_wb_data;
   assign retire_cnt = r_cnt;
   assign err_flags  = r_err;

   // wbsel 3 is reserved and falls through to the ALU result
   assign w_alu_data = (in_wbsel == 2'd2) ? (in_pc + 32'd4) : in_alu;

   always_comb begin
      w_ld_bad = 1'b0;
      case (in_funct3)
         3'd1, 3'd5: w_ld_bad = in_alu[0];
         3'd2:       w_ld_bad = (in_alu[1:0] != 2'b00);
         3'd3, 3'd6, 3'd7: w_ld_bad = 1'b1;
         default:    w_ld_bad = 1'b0;
      endcase
   end

   // Misaligned halfwords only look at addr[1]; bad/misaligned words pass through.
   assign w_byte = ld_rsp_data[{r_ld_off, 3'b000} +: 8];
   assign w_half = r_ld_off[1] ? ld_rsp_data[31:16] : ld_rsp_data[15:0];

   always_comb begin
      w_ld_data = ld_rsp_data;
      case (r_ld_f3)
         3'd0:    w_ld_data = {{24{w_byte[7]}}, w_byte};
         3'd1:    w_ld_data = {{16{w_half[15]}}, w_half};
         3'd4:    w_ld_data = {24'd0, w_byte};
         3'd5:    w_ld_data = {16'd0, w_half};
         default: w_ld_data = ld_rsp_data;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_regwen    <= 1'b0;
         r_regd      <= 5'd0;
         r_wb_data   <= 32'd0;
         r_cnt       <= '0;
         r_err       <= 2'b00;
         r_ld_regwen <= 1'b0;
         r_ld_rd     <= 5'd0;
         r_ld_f3     <= 3'd0;
         r_ld_off    <= 2'd0;
      end else begin
         r_regwen <= 1'b0;
         case (r_state)
            IDLE: begin
               if (ld_rsp_valid)
                  r_err[0] <= 1'b1;
               if (in_valid) begin
                  r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                  if (in_wbsel == 2'd1) begin
                     r_ld_regwen <= in_regwen;
                     r_ld_rd     <= in_rd;
                     r_ld_f3     <= in_funct3;
                     r_ld_off    <= in_alu[1:0];
                     r_state     <= WAIT_LD;
                     if (w_ld_bad)
                        r_err[1] <= 1'b1;
                  end else if (in_regwen && (in_rd != 5'd0)) begin
                     r_regwen  <= 1'b1;
                     r_regd    <= in_rd;
                     r_wb_data <= w_alu_data;
                  end
               end
            end
            WAIT_LD: begin
               if (ld_rsp_valid) begin
                  r_state <= IDLE;
                  if (r_ld_regwen && (r_ld_rd != 5'd0)) begin
                     r_regwen  <= 1'b1;
                     r_regd    <= r_ld_rd;
                     r_wb_data <= w_ld_data;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus a randomized instruction mix
// checked against a transaction-level model of the writeback rules.
module tb_wb_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_regwen;
   logic [4:0]  in_rd;
   logic [1:0]  in_wbsel;
   logic [31:0] in_alu, in_pc;
   logic [2:0]  in_funct3;
   logic        ld_rsp_valid;
   logic [31:0] ld_rsp_data;
   logic        RegWEn;
   logic [4:0]  regD;
   logic [31:0] wb_data;
   logic        busy;
   logic [31:0] retire_cnt;
   logic [1:0]  err_flags;

   int n_tests = 0;
   int n_fail  = 0;

   // model of the architecturally visible outputs
   logic        m_we, m_busy;
   logic [4:0]  m_rd;
   logic [31:0] m_wb, m_cnt;
   logic [1:0]  m_err;

   wb_stage #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_regwen(in_regwen), .in_rd(in_rd), .in_wbsel(in_wbsel), .in_alu(in_alu),
      .in_pc(in_pc), .in_funct3(in_funct3), .ld_rsp_valid(ld_rsp_valid),
      .ld_rsp_data(ld_rsp_data), .RegWEn(RegWEn), .regD(regD), .wb_data(wb_data),
      .busy(busy), .retire_cnt(retire_cnt), .err_flags(err_flags)
   );

   always #5 clk = ~clk;

   function automatic logic [73:0] obs();
      return {in_ready, busy, RegWEn, regD, wb_data, err_flags, retire_cnt};
   endfunction

   function automatic logic [73:0] expv();
      return {~m_busy, m_busy, m_we, m_rd, m_wb, m_err, m_cnt};
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off,
                                           input logic [31:0] d);
      int unsigned b, h;
      b = (d >> (8 * off)) & 32'hFF;
      h = (off >= 2) ? (d >> 16) : (d & 32'hFFFF);
      case (f3)
         3'd0:    return (b >= 128) ? (b + 32'hFFFFFF00) : b;
         3'd1:    return (h >= 32768) ? (h + 32'hFFFF0000) : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return d;
      endcase
   endfunction

   function automatic bit ref_bad(input logic [2:0] f3, input int off);
      if (f3 == 3 || f3 == 6 || f3 == 7) return 1;
      if ((f3 == 1 || f3 == 5) && (off % 2 == 1)) return 1;
      if (f3 == 2 && off != 0) return 1;
      return 0;
   endfunction

   task automatic m_write(input logic regwen, input logic [4:0] rd, input logic [31:0] v);
      m_we = regwen && (rd != 0);
      if (m_we) begin
         m_rd = rd;
         m_wb = v;
      end
   endtask

   task automatic m_reset();
      m_we = 0; m_busy = 0; m_rd = 0; m_wb = 0; m_cnt = 0; m_err = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [2:0] f3);
      in_valid = v; in_regwen = we; in_rd = rd; in_wbsel = sel;
      in_alu = alu; in_pc = pc; in_funct3 = f3;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      m_reset();
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0, 0, 0, 0);
      ld_rsp_valid = 0; ld_rsp_data = 0;
      reset = 1'b0;
      m_reset();
      tick(); tick();
      n_tests++;
      if (obs() !== expv()) begin
         n_fail++;
         $display("FAIL reset got %h exp %h", obs(), expv());
      end
      reset = 1'b1;
   endtask

   task automatic test_alu_b2b();
      do_reset();
      drive(1, 1, 5, 0, 32'h11, 32'h100, 0);
      tick(); m_cnt++; m_write(1, 5, 32'h11);
      n_tests++;
      if (obs() !== expv()) begin
         n_fail++;
         $display("FAIL alu_b2b_first got %h exp %h", obs(), expv());
      end
      drive(1, 1, 6, 3, 32'h22, 32'h104, 0);
      tick(); m_cnt++; m_write(1, 6, 32'h22);
      n_tests++;
      if (obs() !== expv() || retire_cnt !== 32'd2) begin
         n_fail++;
         $display("FAIL alu_b2b_second got %h exp %h", obs(), expv());
      end
      drive(0, 1, 9, 0, 32'h99, 0, 0);
      tick(); m_we = 0;
      n_tests++;
      if (obs() !== expv()) begin
         n_fail++;
         $display("FAIL alu_b2b_hold got %h exp %h", obs(), expv());
      end
   endtask

   task automatic test_lb_sext();
      drive(1, 1, 7, 1, 32'h1003, 0, 3'd0);
      tick(); m_cnt++; m_we = 0; m_busy = 1;
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if ({in_ready, busy, RegWEn} !== 3'b010) begin
            n_fail++;
            $display("FAIL lb_wait%0d got rdy/busy/we %b exp 010", i, {in_ready, busy, RegWEn});
         end
         if (i == 3) begin
            ld_rsp_valid = 1; ld_rsp_data = 32'h80FF_0000;
         end
         tick();
      end
      ld_rsp_valid = 0;
      m_busy = 0; m_write(1, 7, 32'hFFFF_FF80);
      n_tests++;
      if (obs() !== expv()) begin
         n_fail++;
         $display("FAIL lb_write got %h exp %h", obs(), expv());
      end
   endtask

   task automatic one_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] expd);
      drive(1, 1, 12, 1, addr, 0, f3);
      tick(); m_cnt++; m_we = 0; m_busy = 1;
      drive(0, 0, 0, 0, 0, 0, 0);
      ld_rsp_valid = 1; ld_rsp_data = data;
      tick();
      ld_rsp_valid = 0;
      m_busy = 0; m_write(1, 12, expd);
      n_tests++;
      if (obs() !== expv()) begin
         n_fail++;
         $display("FAIL %s got %h exp %h", nm, obs(), expv());
      end
   endtask

   task automatic test_lh();
      do_reset();
      one_load("lhu", 3'd5, 32'h2002, 32'h8001_1234, 32'h0000_8001);
      one_load("lh", 3'd1, 32'h2002, 32'h8001_1234, 32'hFFFF_8001);
      m_err = 2'b10;
      one_load("lh_misaligned", 3'd1, 32'h2001, 32'h8001_1234, 32'h0000_1234);
   endtask

   task automatic test_jal();
      do_reset();
      drive(1, 1, 1, 2, 32'h5555, 32'hFFFF_FFFC, 0);
      tick(); m_cnt++; m_write(1, 1, 32'h0);
      n_tests++;
      if (obs() !== expv()) begin
         n_fail++;
         $display("FAIL jal_wrap got %h exp %h", obs(), expv());
      end
      drive(1, 1, 0, 2, 32'h5555, 32'h0000_1000, 0);
      tick(); m_cnt++; m_write(1, 0, 32'h1004);
      n_tests++;
      if (obs() !== expv() || retire_cnt !== 32'd2) begin
         n_fail++;
         $display("FAIL jal_rd0 got %h exp %h", obs(), expv());
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      tick(); m_we = 0;
   endtask

   task automatic test_unexpected_rsp();
      ld_rsp_valid = 1; ld_rsp_data = 32'hDEAD_BEEF;
      tick(); m_err[0] = 1; m_we = 0;
      ld_rsp_valid = 0;
      n_tests++;
      if (obs() !== expv()) begin
         n_fail++;
         $display("FAIL unexp_rsp got %h exp %h", obs(), expv());
      end
      tick(); tick();
      n_tests++;
      if (err_flags !== 2'b01) begin
         n_fail++;
         $display("FAIL unexp_sticky got %b exp 01", err_flags);
      end
   endtask

   task automatic test_reset_mid_load();
      drive(1, 1, 9, 1, 32'h3000, 0, 3'd2);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      #1 reset = 1'b0;
      #1 m_reset();
      n_tests++;
      if (obs() !== expv()) begin
         n_fail++;
         $display("FAIL async_reset got %h exp %h", obs(), expv());
      end
      reset = 1'b1;
      ld_rsp_valid = 1; ld_rsp_data = 32'h1234_5678;
      tick(); m_err = 2'b01;
      ld_rsp_valid = 0;
      n_tests++;
      if (obs() !== expv()) begin
         n_fail++;
         $display("FAIL reset_mid_load got %h exp %h", obs(), expv());
      end
   endtask

   task automatic test_random();
      logic        we;
      logic [4:0]  rd;
      logic [1:0]  sel;
      logic [31:0] alu, pc, dat;
      logic [2:0]  f3;
      int          waits;
      do_reset();
      for (int n = 0; n < 300; n++) begin
         we = ($urandom % 4) != 0; rd = 5'($urandom); sel = 2'($urandom);
         alu = $urandom; pc = $urandom; f3 = 3'($urandom); dat = $urandom;
         if ($urandom % 5 == 0) begin
            drive(0, we, rd, sel, alu, pc, f3);
            tick(); m_we = 0;
         end else if (sel != 1) begin
            drive(1, we, rd, sel, alu, pc, f3);
            tick(); m_cnt++;
            m_write(we, rd, (sel == 2) ? pc + 32'd4 : alu);
         end else begin
            drive(1, we, rd, sel, alu, pc, f3);
            tick(); m_cnt++; m_we = 0; m_busy = 1;
            waits = $urandom % 4;
            for (int w = 0; w <= waits; w++) begin
               n_tests++;
               if ({in_ready, busy, RegWEn} !== 3'b010) begin
                  n_fail++;
                  $display("FAIL rand_wait n=%0d got %b exp 010", n, {in_ready, busy, RegWEn});
               end
               drive(1'($urandom), 1, 5'($urandom), 0, $urandom, 0, 0);
               if (w == waits) begin
                  in_valid = 0;
                  ld_rsp_valid = 1; ld_rsp_data = dat;
               end
               tick();
            end
            ld_rsp_valid = 0;
            m_busy = 0;
            m_write(we, rd, ref_load(f3, alu % 4, dat));
            if (ref_bad(f3, alu % 4)) m_err[1] = 1;
         end
         n_tests++;
         if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL rand n=%0d sel=%0d f3=%0d got %h exp %h", n, sel, f3, obs(), expv());
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_alu_b2b();
      test_lb_sext();
      test_lh();
      test_jal();
      test_unexpected_rsp();
      test_reset_mid_load();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
